uart_tx_sched: RTL and testbench

UART transmit scheduler that shares the single UART TX serializer between two result sources: the ALU (2-byte results) and the register file (1-byte read data). It holds one pending result per source and arbitrates round-robin. It breaks ALU results into bytes and drives the TX `data_valid`/`busy` handshake one byte at a time. It sits in the TX clock domain, directly upstream of the UART TX, and is its only driver.

---
 rtl/uart_tx_sched.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART TX serializer between the ALU (2-byte results)
// and the register file (1-byte read data). One pending result per source is
// held and arbitrated round-robin. ALU results go out low byte first. Bytes are
// handed to the TX one at a time over the tx_data_valid / tx_busy handshake.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to re-issue a byte when the
// TX has not raised busy within ACK_TO cycles of the issue.
module uart_tx_sched #(
    parameter int DATA_W = 8,
    parameter int ACK_TO = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_valid,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic                rf_rd_valid,
    input  logic                tx_busy,
    output logic [DATA_W-1:0]   tx_p_data,
    output logic                tx_data_valid,
    output logic                sched_busy,
    output logic                drop_alu,
    output logic                drop_rf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] alu_hold_q, alu_hold_d;
    logic [DATA_W-1:0]   rf_hold_q, rf_hold_d;
    logic                alu_pend_q, alu_pend_d;
    logic                rf_pend_q, rf_pend_d;
    logic                ptr_rf_q, ptr_rf_d;     // 1: RF wins the next contested grant
    logic [2*DATA_W-1:0] buf_q, buf_d;           // bytes still to send, next byte in the low lane
    logic [1:0]          left_q, left_d;
    logic [DATA_W-1:0]   tx_p_data_q, tx_p_data_d;
    logic                tx_dv_q, tx_dv_d;
    logic                drop_alu_q, drop_alu_d;
    logic                drop_rf_q, drop_rf_d;
    logic                can_grant, grant_alu, grant_rf;
    logic                timeout;

    // Arbitration: only from IDLE with the TX free; the pointer breaks ties.
    always_comb begin
        can_grant = (state_q == S_IDLE) && !tx_busy;
        grant_alu = can_grant && alu_pend_q && (!rf_pend_q || !ptr_rf_q);
        grant_rf  = can_grant && rf_pend_q && (!alu_pend_q || ptr_rf_q);
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TO + 1);

    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

    // Count WAIT_ACK cycles without busy; any other state clears it, so each issue gets a full window.
    always_comb begin
        ack_cnt_d = '0;
        if (state_q == S_WAIT_ACK && !tx_busy) begin
            ack_cnt_d = ack_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt_q <= '0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign timeout = (state_q == S_WAIT_ACK) && !tx_busy && (ack_cnt_q == CNT_W'(ACK_TO - 1));
`else
    // ACK_TO has no function in this build.
    logic unused_ack_to;
    assign unused_ack_to = ^ACK_TO;
    assign timeout       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue, wait for the TX to take the byte, wait for it to finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (grant_alu || grant_rf) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx_busy)      state_d = S_WAIT_DONE;
                else if (timeout) state_d = S_ISSUE;
            end
            S_WAIT_DONE: if (!tx_busy) state_d = (left_q > 2'd1) ? S_ISSUE : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Capture, drop detection, grant bookkeeping and the registered TX-side outputs.
    always_comb begin
        // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
        alu_hold_d = alu_hold_q;
        rf_hold_d  = rf_hold_q;
        ptr_rf_d   = ptr_rf_q;
        buf_d      = buf_q;
        left_d     = left_q;

        // A grant frees the slot in the same cycle, so a coinciding strobe is accepted.
        if (alu_valid && (!alu_pend_q || grant_alu)) alu_hold_d = alu_out;
        if (rf_rd_valid && (!rf_pend_q || grant_rf)) rf_hold_d = rf_rd_data;
        alu_pend_d = alu_valid || (alu_pend_q && !grant_alu);
        rf_pend_d  = rf_rd_valid || (rf_pend_q && !grant_rf);
        drop_alu_d = alu_valid && alu_pend_q && !grant_alu;
        drop_rf_d  = rf_rd_valid && rf_pend_q && !grant_rf;

        if (grant_alu) begin
            ptr_rf_d = 1'b1;
            buf_d    = alu_hold_q;
            left_d   = 2'd2;
        end else if (grant_rf) begin
            ptr_rf_d = 1'b0;
            buf_d    = {{DATA_W{1'b0}}, rf_hold_q};
            left_d   = 2'd1;
        end else if (state_q == S_WAIT_DONE && !tx_busy) begin
            buf_d    = buf_q >> DATA_W;
            left_d   = left_q - 2'd1;
        end

        // Every entry to ISSUE (grant, next byte or re-issue) presents the low lane of the buffer.
        tx_dv_d     = (state_d == S_ISSUE);
        tx_p_data_d = (state_d == S_ISSUE) ? buf_d[DATA_W-1:0] : tx_p_data_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: hold and buffer registers are reset too, so a reset discards every pending result.
        if (rst) begin
            alu_hold_q  <= '0;
            rf_hold_q   <= '0;
            alu_pend_q  <= 1'b0;
            rf_pend_q   <= 1'b0;
            ptr_rf_q    <= 1'b0;
            buf_q       <= '0;
            left_q      <= '0;
            tx_p_data_q <= '0;
            tx_dv_q     <= 1'b0;
            drop_alu_q  <= 1'b0;
            drop_rf_q   <= 1'b0;
        end else begin
            alu_hold_q  <= alu_hold_d;
            rf_hold_q   <= rf_hold_d;
            alu_pend_q  <= alu_pend_d;
            rf_pend_q   <= rf_pend_d;
            ptr_rf_q    <= ptr_rf_d;
            buf_q       <= buf_d;
            left_q      <= left_d;
            tx_p_data_q <= tx_p_data_d;
            tx_dv_q     <= tx_dv_d;
            drop_alu_q  <= drop_alu_d;
            drop_rf_q   <= drop_rf_d;
        end
    end

    assign tx_p_data     = tx_p_data_q;
    assign tx_data_valid = tx_dv_q;
    assign sched_busy    = (state_q != S_IDLE);
    assign drop_alu      = drop_alu_q;
    assign drop_rf       = drop_rf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: table-driven single transfers, hand-written
// round-robin / overflow / timeout / reset sequences, and randomized rounds
// checked against a transaction-level reference model of the byte stream.
module tb_uart_tx_sched;

    localparam int DATA_W = 8;
    localparam int ACK_TO = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic [2*DATA_W-1:0] alu_out;
    logic                alu_valid;
    logic [DATA_W-1:0]   rf_rd_data;
    logic                rf_rd_valid;
    logic                tx_busy;
    logic [DATA_W-1:0]   tx_p_data;
    logic                tx_data_valid;
    logic                sched_busy;
    logic                drop_alu;
    logic                drop_rf;

    uart_tx_sched #(.DATA_W(DATA_W), .ACK_TO(ACK_TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out       (alu_out),
        .alu_valid     (alu_valid),
        .rf_rd_data    (rf_rd_data),
        .rf_rd_valid   (rf_rd_valid),
        .tx_busy       (tx_busy),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .sched_busy    (sched_busy),
        .drop_alu      (drop_alu),
        .drop_rf       (drop_rf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation records, cleared per test.
    logic [7:0] got_b[$];
    int         got_c[$];
    int         fall_q[$];
    int         sb_fall_c;
    int         drop_alu_n;
    int         drop_rf_n;
    int         drop_rf_c;

    // Reference model state: expected byte stream and the last granted source.
    logic [7:0] exp_q[$];
    bit         last_alu;

    // TX model controls.
    int tx_len  = 3;
    bit tx_auto = 1'b1;

    typedef struct {
        bit          is_alu;
        logic [15:0] data;
        int          tx_len;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t        vecs[4];
    int          c0;
    int          c22;
    int          pat;
    int          dly;
    bit          rfirst;
    logic [15:0] rad;
    logic [7:0]  rrd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int got_cyc(input int i);
        return (i < got_c.size()) ? got_c[i] : -1000;
    endfunction

    function automatic logic [7:0] got_byte(input int i);
        return (i < got_b.size()) ? got_b[i] : 8'hxx;
    endfunction

    function automatic int last_fall();
        return (fall_q.size() > 0) ? fall_q[fall_q.size()-1] : -1000;
    endfunction

    // Grant of one source: ALU sends low byte then high byte, RF sends its byte.
    function automatic void model_grant(input bit alu, input logic [15:0] ad, input logic [7:0] rd);
        if (alu) begin
            exp_q.push_back(ad[7:0]);
            exp_q.push_back(ad[15:8]);
        end else begin
            exp_q.push_back(rd);
        end
        last_alu = alu;
    endfunction

    // Both pending: the source not granted last goes first.
    function automatic void model_both(input logic [15:0] ad, input logic [7:0] rd);
        if (last_alu) begin
            model_grant(1'b0, ad, rd);
            model_grant(1'b1, ad, rd);
        end else begin
            model_grant(1'b1, ad, rd);
            model_grant(1'b0, ad, rd);
        end
    endfunction

    task automatic clear_obs();
        got_b.delete();
        got_c.delete();
        fall_q.delete();
        exp_q.delete();
        sb_fall_c  = -1000;
        drop_alu_n = 0;
        drop_rf_n  = 0;
        drop_rf_c  = -1000;
    endtask

    // Strobe ALU at offset da and/or RF at offset dr (cycles after the first strobe cycle).
    task automatic send(input bit do_a, input bit do_r, input int da, input int dr,
                        input logic [15:0] ad, input logic [7:0] rd, output int c_first);
        int last_k;
        last_k  = 0;
        c_first = 0;
        if (do_a && da > last_k) last_k = da;
        if (do_r && dr > last_k) last_k = dr;
        for (int k = 0; k <= last_k; k++) begin
            step(1);
            if (k == 0) c_first = cyc;
            alu_out     = ad;
            alu_valid   = do_a && (k == da);
            rf_rd_data  = rd;
            rf_rd_valid = do_r && (k == dr);
        end
        step(1);
        alu_valid   = 1'b0;
        rf_rd_valid = 1'b0;
    endtask

    // Wait for three quiet cycles (scheduler and TX idle) within a bounded budget.
    task automatic wait_idle(input string name);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < 400) begin
            step(1);
            n++;
            if (!sched_busy && !tx_busy) quiet++;
            else quiet = 0;
        end
        check({name, "_idle_reached"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic cmp_bytes(input string name);
        check({name, "_count"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), got_byte(i), exp_q[i]);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_tx_p_data"}, tx_p_data, 32'd0);
        check({name, "_tx_data_valid"}, tx_data_valid, 32'd0);
        check({name, "_sched_busy"}, sched_busy, 32'd0);
        check({name, "_drop_alu"}, drop_alu, 32'd0);
        check({name, "_drop_rf"}, drop_rf, 32'd0);
    endtask

    // Monitor: record issues, drops and sched_busy falling edges mid-cycle.
    initial begin : monitor
        bit prev_sb;
        prev_sb = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid) begin
                got_b.push_back(tx_p_data);
                got_c.push_back(cyc);
            end
            if (drop_alu) drop_alu_n++;
            if (drop_rf) begin
                drop_rf_n++;
                drop_rf_c = cyc;
            end
            if (prev_sb && !sched_busy) sb_fall_c = cyc;
            prev_sb = sched_busy;
        end
    end

    // TX model: busy rises the cycle after data_valid and stays high tx_len cycles.
    initial begin : tx_model
        int remain;
        bit start;
        remain = 0;
        start  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_auto) begin
                if (start) begin
                    tx_busy = 1'b1;
                    remain  = tx_len;
                    start   = 1'b0;
                end else if (remain > 0) begin
                    remain--;
                    if (remain == 0) begin
                        tx_busy = 1'b0;
                        fall_q.push_back(cyc);
                    end
                end
                if (tx_data_valid) start = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        alu_out     = '0;
        alu_valid   = 1'b0;
        rf_rd_data  = '0;
        rf_rd_valid = 1'b0;
        tx_busy     = 1'b0;
        last_alu    = 1'b0;     // pointer at reset = ALU, i.e. RF counts as granted last
        clear_obs();

        vecs[0] = '{is_alu: 1'b0, data: 16'h00A5, tx_len: 3, n: 1, b0: 8'hA5, b1: 8'h00};
        vecs[1] = '{is_alu: 1'b1, data: 16'h1234, tx_len: 3, n: 2, b0: 8'h34, b1: 8'h12};
        vecs[2] = '{is_alu: 1'b1, data: 16'hFF00, tx_len: 1, n: 2, b0: 8'h00, b1: 8'hFF};
        vecs[3] = '{is_alu: 1'b0, data: 16'h005A, tx_len: 5, n: 1, b0: 8'h5A, b1: 8'h00};

        // Reset state
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(2);
        check_zero("post_reset");

        // Table-driven single transfers: content, latency, inter-byte gap, sched_busy fall
        foreach (vecs[i]) begin
            tx_len = vecs[i].tx_len;
            clear_obs();
            send(vecs[i].is_alu, !vecs[i].is_alu, 0, 0, vecs[i].data, vecs[i].data[7:0], c0);
            last_alu = vecs[i].is_alu;
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_count", i), got_b.size(), vecs[i].n);
            check($sformatf("vec%0d_byte0", i), got_byte(0), vecs[i].b0);
            check($sformatf("vec%0d_latency", i), got_cyc(0) - c0, 32'd2);
            if (vecs[i].n == 2) begin
                check($sformatf("vec%0d_byte1", i), got_byte(1), vecs[i].b1);
                check($sformatf("vec%0d_gap", i), got_cyc(1) - (fall_q.size() > 0 ? fall_q[0] : -1000), 32'd1);
            end
            check($sformatf("vec%0d_sched_fall", i), sb_fall_c - last_fall(), 32'd1);
        end

        // Round-robin: both at once, both again, then ALU alone followed by both
        tx_len = 2;
        clear_obs();
        send(1'b1, 1'b1, 0, 0, 16'h1234, 8'hA5, c0);
        model_both(16'h1234, 8'hA5);
        wait_idle("rr1");
        cmp_bytes("rr1");
        check("rr1_first_is_alu_low", got_byte(0), 8'h34);

        clear_obs();
        send(1'b1, 1'b1, 0, 0, 16'hBEEF, 8'h5C, c0);
        model_both(16'hBEEF, 8'h5C);
        wait_idle("rr2");
        cmp_bytes("rr2");

        clear_obs();
        send(1'b1, 1'b0, 0, 0, 16'h0102, 8'h00, c0);
        model_grant(1'b1, 16'h0102, 8'h00);
        wait_idle("rr3a");
        send(1'b1, 1'b1, 0, 0, 16'h0304, 8'h77, c0);
        model_both(16'h0304, 8'h77);
        wait_idle("rr3b");
        cmp_bytes("rr3");
        check("rr3_rf_before_alu", got_byte(2), 8'h77);

        // Overflow: second RF strobe while RF still pending is dropped
        tx_len = 4;
        clear_obs();
        step(1);
        c0        = cyc;
        alu_out   = 16'h1234;
        alu_valid = 1'b1;
        step(1);
        alu_valid = 1'b0;
        step(3);
        rf_rd_data  = 8'h11;
        rf_rd_valid = 1'b1;
        step(1);
        rf_rd_data  = 8'h22;
        c22         = cyc;
        step(1);
        rf_rd_valid = 1'b0;
        model_grant(1'b1, 16'h1234, 8'h00);
        model_grant(1'b0, 16'h0000, 8'h11);
        wait_idle("ovf");
        cmp_bytes("ovf");
        check("ovf_drop_rf_count", drop_rf_n, 32'd1);
        check("ovf_drop_rf_cycle", drop_rf_c - c22, 32'd1);
        check("ovf_drop_alu_count", drop_alu_n, 32'd0);

        // Strobe coinciding with its own grant: accepted, no drop
        tx_len = 2;
        clear_obs();
        step(1);
        rf_rd_data  = 8'h44;
        rf_rd_valid = 1'b1;
        step(1);
        rf_rd_data  = 8'h55;
        step(1);
        rf_rd_valid = 1'b0;
        model_grant(1'b0, 16'h0000, 8'h44);
        model_grant(1'b0, 16'h0000, 8'h55);
        wait_idle("coinc");
        cmp_bytes("coinc");
        check("coinc_drop_rf_count", drop_rf_n, 32'd0);

        // Randomized rounds against the transaction-level model
        for (int r = 0; r < 40; r++) begin
            pat    = int'($urandom_range(0, 3));
            dly    = int'($urandom_range(1, 3));
            rfirst = 1'($urandom_range(0, 1));
            rad    = 16'($urandom);
            rrd    = 8'($urandom);
            tx_len = int'($urandom_range(1, 4));
            clear_obs();
            case (pat)
                0: begin
                    send(1'b1, 1'b0, 0, 0, rad, rrd, c0);
                    model_grant(1'b1, rad, rrd);
                end
                1: begin
                    send(1'b0, 1'b1, 0, 0, rad, rrd, c0);
                    model_grant(1'b0, rad, rrd);
                end
                2: begin
                    send(1'b1, 1'b1, 0, 0, rad, rrd, c0);
                    model_both(rad, rrd);
                end
                default: begin
                    if (rfirst) begin
                        send(1'b1, 1'b1, dly, 0, rad, rrd, c0);
                        model_grant(1'b0, rad, rrd);
                        model_grant(1'b1, rad, rrd);
                    end else begin
                        send(1'b1, 1'b1, 0, dly, rad, rrd, c0);
                        model_grant(1'b1, rad, rrd);
                        model_grant(1'b0, rad, rrd);
                    end
                end
            endcase
            wait_idle($sformatf("rnd%0d", r));
            cmp_bytes($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_drops", r), drop_alu_n + drop_rf_n, 32'd0);
        end

        // Timeout: TX never raises busy
        clear_obs();
        tx_auto = 1'b0;
        tx_busy = 1'b0;
        step(1);
        c0          = cyc;
        rf_rd_data  = 8'h3C;
        rf_rd_valid = 1'b1;
        step(1);
        rf_rd_valid = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        step(28);
        check("to_issue_count", got_b.size(), 32'd2);
        check("to_first_latency", got_cyc(0) - c0, 32'd2);
        check("to_reissue_gap", got_cyc(1) - got_cyc(0), ACK_TO + 1);
        check("to_reissue_byte", got_byte(1), 8'h3C);
`else
        step(100);
        check("to_issue_count", got_b.size(), 32'd1);
        check("to_first_latency", got_cyc(0) - c0, 32'd2);
`endif
        check("to_first_byte", got_byte(0), 8'h3C);
        check("to_still_busy", sched_busy, 32'd1);
        tx_busy = 1'b1;
        step(3);
        tx_busy = 1'b0;
        tx_auto = 1'b1;
        wait_idle("to");
        last_alu = 1'b0;

        // Reset mid-frame during WAIT_DONE of the first ALU byte
        tx_len = 5;
        clear_obs();
        step(1);
        c0        = cyc;
        alu_out   = 16'hCAFE;
        alu_valid = 1'b1;
        step(1);
        alu_valid = 1'b0;
        step(4);
        check("rstmf_busy_before", sched_busy, 32'd1);
        rst = 1'b1;
        #1;
        check_zero("rstmf");
        step(2);
        rst = 1'b0;
        wait_idle("rstmf");
        check("rstmf_count", got_b.size(), 32'd1);
        check("rstmf_byte0", got_byte(0), 8'hFE);
        last_alu = 1'b0;

        // Pointer back at ALU after reset
        tx_len = 2;
        clear_obs();
        send(1'b1, 1'b1, 0, 0, 16'h5678, 8'h9A, c0);
        model_both(16'h5678, 8'h9A);
        wait_idle("postrst");
        cmp_bytes("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
